bf_code_loader: RTL and testbench

//  Upstream stage of the brainfuck core: receives program bytes from the host byte stream (UART RX side)
//  and writes them into the code RAM write port, null-terminated so the core halts at program end.

---
 rtl/bf_code_loader_pkg.sv | 6 +
 rtl/bf_code_loader.sv | 140 ++++++++++++++
 tb/tb_bf_code_loader.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bf_code_loader_pkg.sv
// bf_code_loader_pkg: shared state encoding and byte constants for the code loader
package bf_code_loader_pkg;
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CHECK, S_RUN, S_ERROR} state_t;
    localparam logic [7:0] LOAD_CMD_DEF = 8'h1B;
    localparam logic [7:0] BF_END       = 8'h00;
endpackage

// File: rtl/bf_code_loader.sv
// bf_code_loader: host byte stream to null-terminated code RAM image, core reset control; LOADER_CHECKSUM_EN adds a checksum byte check
module bf_code_loader
    import bf_code_loader_pkg::*;
#(
    parameter int         addrSize_code = 9,
    parameter bit         BOOT_RUN      = 1'b0,
    parameter logic [7:0] LOAD_CMD      = LOAD_CMD_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     rx_valid,
    input  logic [7:0]               rx_data,
    output logic                     code_we,
    output logic [addrSize_code-1:0] code_addr,
    output logic [7:0]               code_wdata,
    output logic                     core_reset_n,
    output logic                     rx_pass_valid,
    output logic [7:0]               rx_pass_data,
    output logic                     busy,
    output logic                     overflow,
    output logic                     error,
    output logic [addrSize_code:0]   loaded_len
);
    localparam logic [addrSize_code-1:0] PTR_MAX = '1;
    localparam logic [addrSize_code-1:0] PTR_ONE = {{(addrSize_code-1){1'b0}}, 1'b1};
    localparam logic [addrSize_code:0]   LEN_ONE = {{addrSize_code{1'b0}}, 1'b1};
    state_t state, nxt_state;
    logic [addrSize_code-1:0] ptr, nxt_ptr, nxt_code_addr;
    logic [7:0] nxt_code_wdata, nxt_pass_data;
    logic [addrSize_code:0] nxt_len;
    logic nxt_code_we, nxt_core_reset_n, nxt_pass_valid, nxt_busy, nxt_overflow, nxt_error;
    logic cmd, last;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] sum, nxt_sum;
`endif
    assign cmd  = rx_valid && rx_data == LOAD_CMD;
    assign last = rx_data == BF_END || ptr == PTR_MAX;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= BOOT_RUN ? S_RUN : S_IDLE;
            ptr           <= '0;
            code_we       <= 1'b0;
            code_addr     <= '0;
            code_wdata    <= '0;
            core_reset_n  <= BOOT_RUN;
            rx_pass_valid <= 1'b0;
            rx_pass_data  <= '0;
            busy          <= 1'b0;
            overflow      <= 1'b0;
            error         <= 1'b0;
            loaded_len    <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum           <= '0;
`endif
        end else begin
            state         <= nxt_state;
            ptr           <= nxt_ptr;
            code_we       <= nxt_code_we;
            code_addr     <= nxt_code_addr;
            code_wdata    <= nxt_code_wdata;
            core_reset_n  <= nxt_core_reset_n;
            rx_pass_valid <= nxt_pass_valid;
            rx_pass_data  <= nxt_pass_data;
            busy          <= nxt_busy;
            overflow      <= nxt_overflow;
            error         <= nxt_error;
            loaded_len    <= nxt_len;
`ifdef LOADER_CHECKSUM_EN
            sum           <= nxt_sum;
`endif
        end
    end

    always_comb begin
        nxt_state        = state;
        nxt_ptr          = ptr;
        nxt_code_we      = 1'b0;
        nxt_code_addr    = code_addr;
        nxt_code_wdata   = code_wdata;
        nxt_core_reset_n = core_reset_n;
        nxt_pass_valid   = 1'b0;
        nxt_pass_data    = rx_pass_data;
        nxt_busy         = busy;
        nxt_overflow     = overflow;
        nxt_error        = error;
        nxt_len          = loaded_len;
`ifdef LOADER_CHECKSUM_EN
        nxt_sum          = sum;
`endif
        case (state)
            S_LOAD: if (rx_valid) begin
                nxt_code_we    = 1'b1;
                nxt_code_addr  = ptr;
                nxt_code_wdata = last ? BF_END : rx_data;
                if (last) begin
                    nxt_len      = {1'b0, ptr} + LEN_ONE;
                    nxt_overflow = rx_data != BF_END;
`ifdef LOADER_CHECKSUM_EN
                    nxt_state    = S_CHECK;
`else
                    nxt_state    = S_RUN;
`endif
                end else begin
                    nxt_ptr = ptr + PTR_ONE;
`ifdef LOADER_CHECKSUM_EN
                    nxt_sum = sum + rx_data;
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHECK: if (rx_valid) begin
                nxt_state = rx_data == sum ? S_RUN : S_ERROR;
                nxt_busy  = rx_data == sum;
                nxt_error = rx_data != sum;
            end
`endif
            default: begin
                if (state == S_RUN) begin
                    nxt_core_reset_n = 1'b1;
                    nxt_busy         = 1'b0;
                end
                if (cmd) begin
                    nxt_state        = S_LOAD;
                    nxt_core_reset_n = 1'b0;
                    nxt_busy         = 1'b1;
                    nxt_ptr          = '0;
                    nxt_overflow     = 1'b0;
                    nxt_error        = 1'b0;
`ifdef LOADER_CHECKSUM_EN
                    nxt_sum          = '0;
`endif
                end else if (rx_valid && state == S_RUN) begin
                    nxt_pass_valid = 1'b1;
                    nxt_pass_data  = rx_data;
                end
            end
        endcase
    end
endmodule

// File: tb/tb_bf_code_loader.sv
// tb_bf_code_loader: randomized load/run scenarios checked against a program-level reference model
module tb_bf_code_loader;
    localparam int AW = 3;
    localparam int MAX = 2 ** AW - 1;
    localparam logic [7:0] CMD = 8'h1B;
    logic clk = 1'b0;
    logic reset, rx_valid;
    logic [7:0] rx_data;
    logic code_we, core_reset_n, rx_pass_valid, busy, overflow, error;
    logic [AW-1:0] code_addr;
    logic [7:0] code_wdata, rx_pass_data;
    logic [AW:0] loaded_len;
    int errors = 0;
    int checks = 0;
    logic [7:0] prog[$];
    logic [7:0] exp_w[$];
    bit exp_ovf;
    logic [7:0] exp_sum;

    always #5 clk = ~clk;

    bf_code_loader #(.addrSize_code(AW), .BOOT_RUN(1'b0), .LOAD_CMD(CMD)) dut (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .code_we(code_we), .code_addr(code_addr), .code_wdata(code_wdata),
        .core_reset_n(core_reset_n), .rx_pass_valid(rx_pass_valid), .rx_pass_data(rx_pass_data),
        .busy(busy), .overflow(overflow), .error(error), .loaded_len(loaded_len)
    );

    // expected RAM image: bytes up to terminator, truncated to the last address, always 0-terminated
    function automatic void model(input logic [7:0] p[$]);
        exp_w.delete();
        exp_ovf = 1'b0;
        exp_sum = 8'h00;
        foreach (p[i]) begin
            if (p[i] == 8'h00 || i == MAX) begin
                exp_w.push_back(8'h00);
                exp_ovf = p[i] != 8'h00;
                return;
            end
            exp_w.push_back(p[i]);
            exp_sum = exp_sum + p[i];
        end
    endfunction

    task automatic load_body(input logic [7:0] p[$], input bit bad, input string nm);
        logic [AW-1:0] wa;
        model(p);
        for (int i = 0; i <= exp_w.size(); i++) begin
            @(negedge clk);
            if (i == 0) begin
                checks++;
                if ({busy, core_reset_n, code_we, rx_pass_valid} !== 4'b1000) begin
                    errors++;
                    $display("FAIL %s enter: busy/crn/we/pass=%b want 1000", nm, {busy, core_reset_n, code_we, rx_pass_valid});
                end
            end else begin
                wa = AW'(i - 1);
                checks++;
                if ({code_we, code_addr, code_wdata, core_reset_n} !== {1'b1, wa, exp_w[i-1], 1'b0}) begin
                    errors++;
                    $display("FAIL %s write%0d: got we=%b addr=%0d data=%h crn=%b want we=1 addr=%0d data=%h crn=0",
                             nm, i - 1, code_we, code_addr, code_wdata, core_reset_n, wa, exp_w[i-1]);
                end
            end
            if (i < exp_w.size()) begin
                rx_valid = 1'b1;
                rx_data = p[i];
            end
        end
`ifdef LOADER_CHECKSUM_EN
        rx_valid = 1'b1;
        rx_data = bad ? exp_sum + 8'd1 : exp_sum;
        @(negedge clk);
        rx_valid = 1'b0;
        checks++;
        if ({error, core_reset_n, busy} !== (bad ? 3'b100 : 3'b001)) begin
            errors++;
            $display("FAIL %s check: err/crn/busy=%b bad=%b", nm, {error, core_reset_n, busy}, bad);
        end
        if (!bad) begin
            @(negedge clk);
            checks++;
            if ({core_reset_n, busy} !== 2'b10) begin
                errors++;
                $display("FAIL %s release: crn/busy=%b want 10", nm, {core_reset_n, busy});
            end
        end
`else
        rx_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({error, core_reset_n, busy, code_we} !== 4'b0100) begin
            errors++;
            $display("FAIL %s release: err/crn/busy/we=%b want 0100 bad=%b", nm, {error, core_reset_n, busy, code_we}, bad);
        end
`endif
        checks++;
        if (loaded_len !== exp_w.size() || overflow !== exp_ovf) begin
            errors++;
            $display("FAIL %s len: got len=%0d ovf=%b want len=%0d ovf=%b", nm, loaded_len, overflow, exp_w.size(), exp_ovf);
        end
    endtask

    task automatic do_load(input logic [7:0] p[$], input bit bad, input string nm);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data = CMD;
        load_body(p, bad, nm);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        rx_valid = 1'b1;
        rx_data = CMD;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        rx_valid = 1'b0;
        checks++;
        if ({code_we, code_addr, code_wdata, core_reset_n, rx_pass_valid, rx_pass_data, busy, overflow, error, loaded_len} !== '0) begin
            errors++;
            $display("FAIL reset_values: we=%b addr=%0d wd=%h crn=%b pv=%b pd=%h busy=%b ovf=%b err=%b len=%0d want all 0",
                     code_we, code_addr, code_wdata, core_reset_n, rx_pass_valid, rx_pass_data, busy, overflow, error, loaded_len);
        end
        prog = {8'h2B, 8'h2E};
        foreach (prog[i]) begin
            rx_valid = 1'b1;
            rx_data = prog[i];
            @(negedge clk);
            rx_valid = 1'b0;
            checks++;
            if ({code_we, rx_pass_valid, busy, core_reset_n} !== 4'b0000) begin
                errors++;
                $display("FAIL idle_drop%0d: we/pass/busy/crn=%b want 0000", i, {code_we, rx_pass_valid, busy, core_reset_n});
            end
        end
    endtask

    task automatic test_basic_load();
        prog = {8'h2B, 8'h2E, 8'h00};
        do_load(prog, 1'b0, "basic");
    endtask

    task automatic test_run();
        logic [7:0] b;
        for (int k = 0; k < 8; k++) begin
            b = 8'($urandom_range(0, 255));
            if (b == CMD) b = 8'h41;
            @(negedge clk);
            rx_valid = 1'b1;
            rx_data = b;
            @(negedge clk);
            rx_valid = 1'b0;
            checks++;
            if ({rx_pass_valid, rx_pass_data, code_we} !== {1'b1, b, 1'b0}) begin
                errors++;
                $display("FAIL run_pass%0d: pv=%b pd=%h we=%b want pv=1 pd=%h we=0", k, rx_pass_valid, rx_pass_data, code_we, b);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        @(negedge clk);
        checks++;
        if (rx_pass_valid !== 1'b0) begin
            errors++;
            $display("FAIL run_pulse: pv=%b want 0", rx_pass_valid);
        end
        rx_valid = 1'b1;
        rx_data = CMD;
        prog = {8'h00};
        load_body(prog, 1'b0, "reload_empty");
    endtask

    task automatic test_random_loads();
        for (int k = 0; k < 8; k++) begin
            int n;
            n = (k == 0) ? 7 : (k == 1) ? 8 : int'($urandom_range(0, 8));
            prog.delete();
            for (int i = 0; i < n; i++)
                prog.push_back(($urandom_range(0, 3) == 0) ? CMD : 8'($urandom_range(1, 255)));
            if (n <= MAX) prog.push_back(8'h00);
            do_load(prog, 1'b0, $sformatf("rand%0d", k));
        end
    endtask

    task automatic test_overflow();
        prog.delete();
        repeat (9) prog.push_back(8'h2B);
        do_load(prog, 1'b0, "overflow");
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data = 8'h2B;
        @(negedge clk);
        rx_valid = 1'b0;
        checks++;
        if ({rx_pass_valid, rx_pass_data, code_we, overflow} !== {1'b1, 8'h2B, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL overflow_tail: pv=%b pd=%h we=%b ovf=%b want 1 2b 0 1", rx_pass_valid, rx_pass_data, code_we, overflow);
        end
    endtask

    task automatic test_checksum();
        prog = {8'h2B, 8'h2D, 8'h00};
`ifdef LOADER_CHECKSUM_EN
        do_load(prog, 1'b1, "cksum_bad");
`endif
        do_load(prog, 1'b0, "cksum_good");
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data = CMD;
        @(negedge clk);
        rx_data = 8'h2B;
        @(negedge clk);
        checks++;
        if ({code_we, code_addr, code_wdata} !== {1'b1, 3'd0, 8'h2B}) begin
            errors++;
            $display("FAIL midreset_write: we=%b addr=%0d wd=%h want 1 0 2b", code_we, code_addr, code_wdata);
        end
        rx_data = 8'h2E;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        rx_valid = 1'b0;
        checks++;
        if ({code_we, code_addr, core_reset_n, busy, loaded_len} !== '0) begin
            errors++;
            $display("FAIL midreset_values: we=%b addr=%0d crn=%b busy=%b len=%0d want all 0", code_we, code_addr, core_reset_n, busy, loaded_len);
        end
        rx_valid = 1'b1;
        rx_data = 8'h2D;
        @(negedge clk);
        rx_valid = 1'b0;
        checks++;
        if ({code_we, busy, core_reset_n} !== 3'b000) begin
            errors++;
            $display("FAIL midreset_idle: we/busy/crn=%b want 000", {code_we, busy, core_reset_n});
        end
        prog = {8'h41, 8'h00};
        do_load(prog, 1'b0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_run();
        test_random_loads();
        test_overflow();
        test_checksum();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
